// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the shared regfile write port: round-robin grant with a
// bounded burst lock, x0 write dropping and read-after-write hazard flags.
module regfile_wb_arbiter #(
    parameter int  NREQ     = 3,
    parameter int  ADDR_W   = 5,
    parameter int  DATA_W   = 32,
    parameter int  MAX_LOCK = 8,
    localparam int GID_W    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   we,
    output logic [ADDR_W-1:0]      waddr,
    output logic [DATA_W-1:0]      wdata,
    output logic [GID_W-1:0]       grant_id,
    input  logic [ADDR_W-1:0]      rs1_addr,
    input  logic [ADDR_W-1:0]      rs2_addr,
    output logic                   rs1_hazard,
    output logic                   rs2_hazard
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [GID_W-1:0]  ptr_q, ptr_d;
    logic [GID_W-1:0]  owner_q, owner_d;
    logic [GID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];
    logic [NREQ-1:0]   is_x0;
    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   ready_c;
    logic [GID_W-1:0]  win_id;
    logic              win_found;

    function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] id);
        if (int'(id) >= NREQ - 1) begin
            return {GID_W{1'b0}};
        end else begin
            return id + GID_W'(1);
        end
    endfunction

    // Unpack requester buses and classify each beat as x0 drop or real candidate.
    always_comb begin
        is_x0 = {NREQ{1'b0}};
        cand  = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_a[i] = req_data[i*DATA_W +: DATA_W];
            is_x0[i]  = req_valid[i] && (addr_a[i] == {ADDR_W{1'b0}});
            cand[i]   = req_valid[i] && !is_x0[i];
        end
    end

    // Round-robin search: scanning downward leaves the lowest offset from ptr as winner.
    always_comb begin
        logic [GID_W-1:0] idx;
        idx       = {GID_W{1'b0}};
        win_id    = {GID_W{1'b0}};
        win_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx       = GID_W'((int'(ptr_q) + k) % NREQ);
            win_id    = cand[idx] ? idx : win_id;
            win_found = win_found | cand[idx];
        end
    end

    // Next-state, handshake and write-beat selection.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        count_d    = count_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        grant_id_d = grant_id_q;
        ready_c    = is_x0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    ready_c[win_id] = 1'b1;
                    we_d            = 1'b1;
                    waddr_d         = addr_a[win_id];
                    wdata_d         = data_a[win_id];
                    grant_id_d      = win_id;
                    ptr_d           = next_ptr(win_id);
                    if (req_lock[win_id] && (MAX_LOCK > 1)) begin
                        state_d = ST_LOCKED;
                        owner_d = win_id;
                        count_d = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (req_valid[owner_q]) begin
                    ready_c[owner_q] = 1'b1;
                    count_d          = count_q + CNT_W'(1);
                    if (cand[owner_q]) begin
                        we_d       = 1'b1;
                        waddr_d    = addr_a[owner_q];
                        wdata_d    = data_a[owner_q];
                        grant_id_d = owner_q;
                    end else begin
                        we_d = 1'b0;
                    end
                    if (!req_lock[owner_q] || (count_d >= CNT_W'(MAX_LOCK))) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= {GID_W{1'b0}};
            owner_q    <= {GID_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            we_q       <= 1'b0;
            waddr_q    <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            grant_id_q <= {GID_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign req_ready  = rst ? {NREQ{1'b0}} : ready_c;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign grant_id   = grant_id_q;
    // A read launched now returns the pre-write value of the beat on the port.
    assign rs1_hazard = we_q && (waddr_q == rs1_addr) && (waddr_q != {ADDR_W{1'b0}});
    assign rs2_hazard = we_q && (waddr_q == rs2_addr) && (waddr_q != {ADDR_W{1'b0}});

endmodule
